// File: rtl/y86_bus_pkg.sv
// Shared types and byte-lane helpers for the y86 core-to-SRAM bus bridge.
package y86_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MEM_AW_DEFAULT = 14;

  // half=0: lanes of the first (lower) word; half=1: lanes spilling into the next word
  function automatic logic [3:0] lane_be(input logic [1:0] off, input logic half);
    logic [7:0] m;
    m = 8'h0F << off;
    return half ? m[7:4] : m[3:0];
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] off,
                                             input logic half);
    logic [63:0] s;
    s = {32'h0, data} << {off, 3'b000};
    return half ? s[63:32] : s[31:0];
  endfunction

endpackage

// File: rtl/y86_lane_align.sv
// Combinational byte-lane rotate/merge between the byte-addressed core bus and word-wide SRAM.
module y86_lane_align
  import y86_bus_pkg::*;
(
  input  logic [1:0]  off,
  input  logic        half,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_out
);

  logic [63:0] cat;

  always_comb begin
    be         = lane_be(off, half);
    wdata_lane = lane_shift(wdata, off, half);
    cat        = {rdata_in, lo} >> {off, 3'b000};
    rdata_out  = (off == 2'd0) ? rdata_in : cat[31:0];
  end

endmodule

// File: rtl/y86_bus_bridge.sv
// Bridges the y86 core's byte-addressed bus onto a word-aligned synchronous SRAM,
// splitting unaligned accesses into two word accesses.
module y86_bus_bridge
  import y86_bus_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err_oob
);

  localparam logic [MEM_AW-1:0] WORD_ONE = 1;

  state_t            state, state_nx;
  logic [1:0]        off, off_q, off_nx;
  logic [MEM_AW-1:0] w, w1, w1_q, w1_nx;
  logic [31:0]       wdata_q, wdata_nx, lo_q, lo_nx;
  logic              rd_q, rd_nx, rd_valid, rd_valid_nx;
  logic              oob;
  logic              ready_nx, en_nx, we_nx, err_nx;
  logic [MEM_AW-1:0] addr_nx;
  logic [3:0]        be_nx;
  logic [31:0]       wd_nx;

  logic              al_half;
  logic [1:0]        al_off;
  logic [31:0]       al_wdata, al_wlane, al_rdata;
  logic [3:0]        al_be;

  assign off = cpu_addr[1:0];
  assign w   = cpu_addr[MEM_AW+1:2];
  assign w1  = w + WORD_ONE;
  assign oob = |cpu_addr[31:MEM_AW+2];

  assign al_half  = (state == ACC0);
  assign al_off   = (state == IDLE) ? off : off_q;
  assign al_wdata = (state == IDLE) ? cpu_wdata : wdata_q;

  y86_lane_align u_align (
    .off       (al_off),
    .half      (al_half),
    .wdata     (al_wdata),
    .lo        (lo_q),
    .rdata_in  (mem_rdata),
    .be        (al_be),
    .wdata_lane(al_wlane),
    .rdata_out (al_rdata)
  );

  // SRAM data is only valid in DONE, so the read path is a gated mux off the SRAM output register
  assign cpu_rdata = rd_valid ? al_rdata : '0;

  always_comb begin
    state_nx    = state;
    ready_nx    = 1'b0;
    rd_valid_nx = 1'b0;
    en_nx       = 1'b0;
    we_nx       = 1'b0;
    addr_nx     = '0;
    be_nx       = '0;
    wd_nx       = '0;
    err_nx      = err_oob;
    off_nx      = off_q;
    w1_nx       = w1_q;
    wdata_nx    = wdata_q;
    lo_nx       = lo_q;
    rd_nx       = rd_q;
    case (state)
      IDLE: begin
        if (cpu_re || cpu_we) begin
          if (oob || (cpu_re && cpu_we)) begin
            err_nx   = 1'b1;
            ready_nx = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = ACC0;
            en_nx    = 1'b1;
            we_nx    = cpu_we;
            addr_nx  = w;
            be_nx    = cpu_re ? 4'hF : al_be;
            wd_nx    = cpu_re ? '0 : al_wlane;
            off_nx   = off;
            w1_nx    = w1;
            wdata_nx = cpu_wdata;
            rd_nx    = cpu_re;
          end
        end
      end
      ACC0: begin
        if (off_q != 2'd0) begin
          state_nx = ACC1;
          en_nx    = 1'b1;
          we_nx    = !rd_q;
          addr_nx  = w1_q;
          be_nx    = rd_q ? 4'hF : al_be;
          wd_nx    = rd_q ? '0 : al_wlane;
        end else begin
          state_nx    = DONE;
          ready_nx    = 1'b1;
          rd_valid_nx = rd_q;
        end
      end
      ACC1: begin
        lo_nx       = mem_rdata;
        state_nx    = DONE;
        ready_nx    = 1'b1;
        rd_valid_nx = rd_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      rd_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      err_oob   <= 1'b0;
      off_q     <= '0;
      w1_q      <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      rd_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_ready <= ready_nx;
      rd_valid  <= rd_valid_nx;
      mem_en    <= en_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_be    <= be_nx;
      mem_wdata <= wd_nx;
      err_oob   <= err_nx;
      off_q     <= off_nx;
      w1_q      <= w1_nx;
      wdata_q   <= wdata_nx;
      lo_q      <= lo_nx;
      rd_q      <= rd_nx;
    end
  end

endmodule

// File: tb/tb_y86_bus_bridge.sv
// Directed bench for y86_bus_bridge with a behavioural synchronous SRAM.
module tb_y86_bus_bridge;

  localparam int unsigned AW    = 14;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cpu_addr = '0;
  logic          cpu_re = 1'b0;
  logic          cpu_we = 1'b0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          err_oob;

  logic [31:0] mem [0:WORDS-1];

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned n_acc;
  int unsigned acc_lat  [0:3];
  logic [31:0] acc_addr [0:3];
  logic [3:0]  acc_be   [0:3];
  logic [31:0] acc_wd   [0:3];
  logic        acc_we   [0:3];
  int unsigned lat;
  logic [31:0] rdata;

  y86_bus_bridge #(.MEM_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_re   (cpu_re),
    .cpu_we   (cpu_we),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err_oob  (err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, log SRAM accesses per cycle, return latency to cpu_ready (0 = timeout)
  task automatic req(input logic [31:0] a, input logic re, input logic we, input logic [31:0] wd);
    @(negedge clk);
    cpu_addr  = a;
    cpu_re    = re;
    cpu_we    = we;
    cpu_wdata = wd;
    n_acc     = 0;
    lat       = 0;
    rdata     = 'x;
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_en && n_acc < 4) begin
        acc_lat[n_acc]  = c;
        acc_addr[n_acc] = 32'(mem_addr);
        acc_be[n_acc]   = mem_be;
        acc_wd[n_acc]   = mem_wdata;
        acc_we[n_acc]   = mem_we;
        n_acc++;
      end
      if (cpu_ready) begin
        lat   = c;
        rdata = cpu_rdata;
        break;
      end
    end
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    if (lat == 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) mem[i] = '0;

    #1;
    check("rst_ready", 32'(cpu_ready), 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_mem_en", 32'({mem_en, mem_we}), 0);
    check("rst_addr_be", 32'({mem_addr, mem_be}), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_err", 32'(err_oob), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: aligned read
    mem[4] = 32'hDDCCBBAA;
    req(32'h10, 1'b1, 1'b0, '0);
    check("t1_lat", lat, 2);
    check("t1_nacc", n_acc, 1);
    check("t1_acc_cycle", acc_lat[0], 1);
    check("t1_addr", acc_addr[0], 4);
    check("t1_be", 32'(acc_be[0]), 32'hF);
    check("t1_rdata", rdata, 32'hDDCCBBAA);

    // 2: unaligned read
    mem[4] = 32'h44332211;
    mem[5] = 32'h88776655;
    req(32'h13, 1'b1, 1'b0, '0);
    check("t2_lat", lat, 3);
    check("t2_nacc", n_acc, 2);
    check("t2_addr0", acc_addr[0], 4);
    check("t2_addr1", acc_addr[1], 5);
    check("t2_rdata", rdata, 32'h77665544);

    // 3: unaligned write
    mem[3] = 32'h11111111;
    mem[4] = 32'h22222222;
    req(32'h0E, 1'b0, 1'b1, 32'hA1B2C3D4);
    check("t3_lat", lat, 3);
    check("t3_nacc", n_acc, 2);
    check("t3_acc0", {acc_addr[0][27:0], acc_be[0]}, {28'd3, 4'b1100});
    check("t3_wd0", acc_wd[0], 32'hC3D40000);
    check("t3_acc1", {acc_addr[1][27:0], acc_be[1]}, {28'd4, 4'b0011});
    check("t3_wd1", acc_wd[1], 32'h0000A1B2);
    check("t3_we", 32'({acc_we[0], acc_we[1]}), 32'b11);
    check("t3_mem3", mem[3], 32'hC3D41111);
    check("t3_mem4", mem[4], 32'h2222A1B2);

    // aligned write
    req(32'h20, 1'b0, 1'b1, 32'hCAFEF00D);
    check("aw_lat", lat, 2);
    check("aw_be", 32'(acc_be[0]), 32'hF);
    check("aw_mem8", mem[8], 32'hCAFEF00D);

    // 4: wrap past top of SRAM
    mem[WORDS-1] = 32'hAABBCCDD;
    mem[0]       = 32'h11223344;
    req(32'(4 * WORDS - 2), 1'b1, 1'b0, '0);
    check("t4_lat", lat, 3);
    check("t4_addr0", acc_addr[0], WORDS - 1);
    check("t4_addr1", acc_addr[1], 0);
    check("t4_rdata", rdata, 32'h3344AABB);
    check("t4_err", 32'(err_oob), 0);

    // 5a: out of bounds
    req(32'h0010_0000, 1'b1, 1'b0, '0);
    check("t5a_lat", lat, 1);
    check("t5a_nacc", n_acc, 0);
    check("t5a_rdata", rdata, 0);
    check("t5a_err", 32'(err_oob), 1);
    mem[4] = 32'h0BADC0DE;
    req(32'h10, 1'b1, 1'b0, '0);
    check("t5a_after_rdata", rdata, 32'h0BADC0DE);
    check("t5a_sticky", 32'(err_oob), 1);

    // 5b: simultaneous read and write
    do_reset();
    check("t5b_err_cleared", 32'(err_oob), 0);
    req(32'h10, 1'b1, 1'b1, 32'hFFFFFFFF);
    check("t5b_lat", lat, 1);
    check("t5b_nacc", n_acc, 0);
    check("t5b_rdata", rdata, 0);
    check("t5b_err", 32'(err_oob), 1);
    check("t5b_mem4", mem[4], 32'h0BADC0DE);

    // 6: reset during ACC1 of an unaligned write
    do_reset();
    mem[3] = '0;
    mem[4] = '0;
    @(negedge clk);
    cpu_addr  = 32'h0E;
    cpu_we    = 1'b1;
    cpu_wdata = 32'h55667788;
    @(negedge clk);
    @(negedge clk);
    check("t6_in_acc1", {mem_en, mem_we, 2'b00, mem_be, 24'(mem_addr)}, {4'b1100, 4'b0011, 24'd4});
    rst = 1'b1;
    #1;
    check("t6_out_ctl", 32'({cpu_ready, mem_en, mem_we, err_oob}), 0);
    check("t6_out_addr_be", 32'({mem_addr, mem_be}), 0);
    check("t6_out_data", mem_wdata | cpu_rdata, 0);
    cpu_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6_mem3", mem[3], 32'h77880000);
    check("t6_mem4", mem[4], 32'h0);
    mem[4] = 32'h600DF00D;
    req(32'h10, 1'b1, 1'b0, '0);
    check("t6_next_lat", lat, 2);
    check("t6_next_rdata", rdata, 32'h600DF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
